// File: rtl/divider_16by8_seq.sv
// Sequential restoring divider: 16-bit dividend by 8-bit divisor, one quotient
// bit per clock, with valid/ready handshakes on the operand and result sides.
module divider_16by8_seq #(
    parameter int DIVIDEND_W = 16,
    parameter int DIVISOR_W  = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DIVIDEND_W-1:0] dividend,
    input  logic [DIVISOR_W-1:0]  divisor,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DIVIDEND_W-1:0] quotient,
    output logic [DIVISOR_W-1:0]  remainder,
    output logic                  div_zero
);

    localparam int CNT_W = $clog2(DIVIDEND_W);
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(DIVIDEND_W - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]            r_state;
    logic [CNT_W-1:0]      r_cnt;
    logic [DIVIDEND_W-1:0] r_work;      // dividend bits shift out, quotient bits shift in
    logic [DIVISOR_W-1:0]  r_div;
    logic [DIVISOR_W-1:0]  r_rem;
    logic                  r_zero;
    logic [DIVIDEND_W-1:0] r_quotient;
    logic [DIVISOR_W-1:0]  r_remainder;
    logic                  r_div_zero;

    logic [DIVISOR_W:0]    w_partial;
    logic                  w_ge;
    logic [DIVISOR_W-1:0]  w_rem_next;
    logic [DIVIDEND_W-1:0] w_quo_next;

    // One restoring step: the partial remainder is one bit wider than the
    // divisor so the shifted-in bit can never be lost before the compare.
    always_comb begin
        w_partial  = {r_rem, r_work[DIVIDEND_W-1]};
        w_ge       = (w_partial >= {1'b0, r_div});
        w_rem_next = w_ge ? DIVISOR_W'(w_partial - {1'b0, r_div})
                          : w_partial[DIVISOR_W-1:0];
        w_quo_next = {r_work[DIVIDEND_W-2:0], w_ge};
    end

    // NOTE: every register here, datapath included, is reset because the
    // result outputs must read zero after reset; sequential state uses <= only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_work      <= '0;
            r_div       <= '0;
            r_rem       <= '0;
            r_zero      <= 1'b0;
            r_quotient  <= '0;
            r_remainder <= '0;
            r_div_zero  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_work  <= dividend;
                        r_div   <= divisor;
                        r_rem   <= '0;
                        r_cnt   <= '0;
                        r_zero  <= (divisor == '0);
                        r_state <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    // A zero divisor skips iterating and resolves on the next edge.
                    if (r_zero) begin
                        r_quotient  <= '1;
                        r_remainder <= r_work[DIVISOR_W-1:0];
                        r_div_zero  <= 1'b1;
                        r_state     <= S_DONE;
                    end else begin
                        r_work <= w_quo_next;
                        r_rem  <= w_rem_next;
                        r_cnt  <= r_cnt + CNT_W'(1);
                        if (r_cnt == LAST_STEP) begin
                            r_quotient  <= w_quo_next;
                            r_remainder <= w_rem_next;
                            r_div_zero  <= 1'b0;
                            r_state     <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = (r_state == S_DONE);
    assign quotient  = r_quotient;
    assign remainder = r_remainder;
    assign div_zero  = r_div_zero;

endmodule

// File: tb/tb_divider_16by8_seq.sv
// Self-checking bench for divider_16by8_seq: directed corner cases, stall,
// mid-division reset, and randomized operands against an arithmetic model.
module tb_divider_16by8_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] dividend = '0;
    logic [7:0]  divisor = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] quotient;
    logic [7:0]  remainder;
    logic        div_zero;

    int total_checks = 0;
    int failed_checks = 0;

    divider_16by8_seq dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .dividend  (dividend),
        .divisor   (divisor),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .quotient  (quotient),
        .remainder (remainder),
        .div_zero  (div_zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total_checks++;
        assert (observed === expected)
        else begin
            failed_checks++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Reference: plain unsigned arithmetic, with the divide-by-zero convention.
    task automatic run_op(input logic [15:0] a, input logic [7:0] b, input int hold);
        logic [15:0] exp_q;
        logic [7:0]  exp_r;
        logic        exp_z;
        int          exp_lat;
        int          lat;
        if (b == 8'd0) begin
            exp_q = 16'hFFFF; exp_r = a[7:0]; exp_z = 1'b1; exp_lat = 1;
        end else begin
            exp_q = a / {8'd0, b}; exp_r = 8'(a % {8'd0, b}); exp_z = 1'b0; exp_lat = 16;
        end

        @(negedge clk);
        check("in_ready_idle", {31'd0, in_ready}, 32'd1);
        in_valid = 1'b1;
        dividend = a;
        divisor  = b;
        @(negedge clk);
        in_valid = 1'b0;
        dividend = 16'($urandom);
        divisor  = 8'($urandom);
        check("in_ready_after_accept", {31'd0, in_ready}, 32'd0);

        lat = 0;
        while (!out_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        check("latency", lat, exp_lat);
        check("quotient", {16'd0, quotient}, {16'd0, exp_q});
        check("remainder", {24'd0, remainder}, {24'd0, exp_r});
        check("div_zero", {31'd0, div_zero}, {31'd0, exp_z});
        check("in_ready_done", {31'd0, in_ready}, 32'd0);

        for (int i = 0; i < hold; i++) begin
            out_ready = 1'b0;
            in_valid  = 1'b1;
            dividend  = 16'($urandom);
            divisor   = 8'($urandom);
            @(negedge clk);
            check("hold_out_valid", {31'd0, out_valid}, 32'd1);
            check("hold_in_ready", {31'd0, in_ready}, 32'd0);
            check("hold_quotient", {16'd0, quotient}, {16'd0, exp_q});
            check("hold_remainder", {24'd0, remainder}, {24'd0, exp_r});
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("out_valid_after_hs", {31'd0, out_valid}, 32'd0);
        check("in_ready_after_hs", {31'd0, in_ready}, 32'd1);
        check("quotient_retained", {16'd0, quotient}, {16'd0, exp_q});
        check("remainder_retained", {24'd0, remainder}, {24'd0, exp_r});
    endtask

    initial begin
        logic [7:0]  ra;
        logic [7:0]  rb;
        logic [15:0] rd;

        // Reset state.
        repeat (2) @(negedge clk);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_quotient", {16'd0, quotient}, 32'd0);
        check("rst_remainder", {24'd0, remainder}, 32'd0);
        check("rst_div_zero", {31'd0, div_zero}, 32'd0);
        rst_n = 1'b1;

        // Directed cases.
        run_op(16'd1000, 8'd7, 0);
        run_op(16'd65535, 8'd255, 0);
        run_op(16'd5, 8'd200, 0);
        run_op(16'd0, 8'd1, 0);
        run_op(16'h1234, 8'd0, 0);
        run_op(16'd1000, 8'd7, 5);

        // Reset during BUSY step 8 discards the operation.
        @(negedge clk);
        in_valid = 1'b1;
        dividend = 16'd60000;
        divisor  = 8'd9;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (8) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_in_ready", {31'd0, in_ready}, 32'd1);
        check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        check("midrst_quotient", {16'd0, quotient}, 32'd0);
        check("midrst_remainder", {24'd0, remainder}, 32'd0);
        check("midrst_div_zero", {31'd0, div_zero}, 32'd0);
        @(negedge clk);
        check("midrst_no_result", {31'd0, out_valid}, 32'd0);
        rst_n = 1'b1;
        run_op(16'd100, 8'd3, 0);

        // Exact products: a*b / b must return a with zero remainder.
        for (int n = 0; n < 1000; n++) begin
            ra = 8'($urandom);
            rb = 8'($urandom_range(1, 255));
            run_op(16'(ra) * 16'(rb), rb, int'($urandom_range(0, 3)));
        end

        // Fully random operands, every eighth one with a zero divisor.
        for (int n = 0; n < 200; n++) begin
            rd = 16'($urandom);
            rb = (n % 8 == 0) ? 8'd0 : 8'($urandom);
            run_op(rd, rb, int'($urandom_range(0, 2)));
        end

        $display("%0d/%0d checks passed", total_checks - failed_checks, total_checks);
        $finish;
    end

endmodule
